// File: rtl/histogram_mm_pkg.sv
// rtl/histogram_mm_pkg.sv - shared types and helpers for the histogram engine
package histogram_mm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RD_REQ,
    RD_WAIT,
    WB_REQ,
    WB_RDWAIT,
    WB_WR,
    DONE
  } state_t;

  // Bin index width (BIN_IDX_W); a 2-bin array still needs one address bit
  function automatic int bin_idx_w(input int num_bins);
    return (num_bins <= 2) ? 1 : $clog2(num_bins);
  endfunction

  // a + b clamped to the largest cnt_w-bit value (cnt_w up to 64)
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int cnt_w);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << cnt_w) - 65'd1;
    return (sum > lim) ? lim[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/histogram_mm_binram.sv
// rtl/histogram_mm_binram.sv - single-port bin counter array with a saturating increment port
module histogram_mm_binram #(
  parameter int NUM_BINS = 256,
  parameter int CNT_W    = 32,
  parameter int IDX_W    = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clr,
  input  logic             inc,
  input  logic [IDX_W-1:0] addr,
  output logic [CNT_W-1:0] rdata,
  output logic             pend
);

  logic [CNT_W-1:0] mem [NUM_BINS];
  logic             inc_q;
  logic [IDX_W-1:0] inc_addr;
  logic [IDX_W-1:0] port_addr;
  logic [CNT_W-1:0] inc_val;

  // The write-back half of an increment owns the single port for one cycle
  assign port_addr = inc_q ? inc_addr : addr;
  assign inc_val   = (rdata == '1) ? rdata : rdata + CNT_W'(1);
  assign pend      = inc_q;

  // Increment pipeline: read the bin this cycle, write it back the next
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      inc_q    <= 1'b0;
      inc_addr <= '0;
    end else begin
      inc_q    <= inc;
      inc_addr <= addr;
    end
  end

  // Array plus registered read port; left unreset so it maps onto block RAM
  always_ff @(posedge clock) begin
    if (clr) begin
      mem[port_addr] <= '0;
    end else if (inc_q) begin
      mem[port_addr] <= inc_val;
    end
    rdata <= mem[port_addr];
  end

endmodule

// File: rtl/histogram_mm.sv
// rtl/histogram_mm.sv - memory-to-memory histogram engine behind a call/return handshake
module histogram_mm
  import histogram_mm_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int BUS_W     = 64,
  parameter int DATA_W    = 32,
  parameter int NUM_BINS  = 256,
  parameter int BIN_SHIFT = 0,
  parameter int CNT_W     = 32
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  output logic                busy,
  output logic                done,
  input  logic                stall,
  input  logic [ADDR_W-1:0]   src_r,
  input  logic [ADDR_W-1:0]   hist_r,
  input  logic [31:0]         n,
  input  logic                accum,
  output logic [31:0]         oor_count,
  output logic [ADDR_W-1:0]   avmm_0_rw_address,
  output logic [BUS_W/8-1:0]  avmm_0_rw_byteenable,
  output logic                avmm_0_rw_read,
  input  logic [BUS_W-1:0]    avmm_0_rw_readdata,
  input  logic                avmm_0_rw_readdatavalid,
  input  logic                avmm_0_rw_waitrequest,
  output logic                avmm_0_rw_write,
  output logic [BUS_W-1:0]    avmm_0_rw_writedata
);

  localparam int BIN_IDX_W = bin_idx_w(NUM_BINS);
  localparam int BYTES     = BUS_W / 8;
  localparam logic [BIN_IDX_W-1:0] BIN_MAX = BIN_IDX_W'(NUM_BINS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_addr_q, wb_addr_q;
  logic [31:0]         n_q, i_q, oor_q;
  logic [BIN_IDX_W-1:0] b_q;
  logic                accum_q;
  logic [CNT_W-1:0]    wb_mem_q;

  logic                latch, b_adv, smp_done, wb_cap, wr_acc;
  logic                ram_clr, ram_inc, ram_pend;
  logic [BIN_IDX_W-1:0] ram_addr;
  logic [CNT_W-1:0]    ram_rdata;
  logic [DATA_W-1:0]   sample_sh;
  logic                in_range, last;
  logic [CNT_W-1:0]    sum;
  logic                unused_rd;

  assign sample_sh = avmm_0_rw_readdata[DATA_W-1:0] >> BIN_SHIFT;
  assign in_range  = sample_sh < DATA_W'(NUM_BINS);
  assign last      = (i_q + 32'd1) == n_q;
  assign sum       = accum_q ? CNT_W'(sat_add(64'(wb_mem_q), 64'(ram_rdata), CNT_W)) : ram_rdata;
  assign unused_rd = ^avmm_0_rw_readdata;

  assign avmm_0_rw_byteenable = '1;
  assign oor_count            = oor_q;

  histogram_mm_binram #(
    .NUM_BINS(NUM_BINS),
    .CNT_W   (CNT_W),
    .IDX_W   (BIN_IDX_W)
  ) u_binram (
    .clock (clock),
    .resetn(resetn),
    .clr   (ram_clr),
    .inc   (ram_inc),
    .addr  (ram_addr),
    .rdata (ram_rdata),
    .pend  (ram_pend)
  );

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state, bus outputs and datapath strobes
  always_comb begin
    state_d             = state_q;
    busy                = (state_q != IDLE);
    done                = 1'b0;
    avmm_0_rw_read      = 1'b0;
    avmm_0_rw_write     = 1'b0;
    avmm_0_rw_address   = '0;
    avmm_0_rw_writedata = '0;
    ram_clr             = 1'b0;
    ram_inc             = 1'b0;
    ram_addr            = b_q;
    latch               = 1'b0;
    b_adv               = 1'b0;
    smp_done            = 1'b0;
    wb_cap              = 1'b0;
    wr_acc              = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          latch   = 1'b1;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        ram_clr = 1'b1;
        b_adv   = 1'b1;
        if (b_q == BIN_MAX) state_d = (n_q == 32'd0) ? WB_REQ : RD_REQ;
      end
      RD_REQ: begin
        avmm_0_rw_read    = 1'b1;
        avmm_0_rw_address = rd_addr_q;
        if (!avmm_0_rw_waitrequest) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (avmm_0_rw_readdatavalid) begin
          smp_done = 1'b1;
          if (in_range) begin
            ram_inc  = 1'b1;
            ram_addr = sample_sh[BIN_IDX_W-1:0];
          end
          state_d = last ? WB_REQ : RD_REQ;
        end
      end
      WB_REQ: begin
        // Wait out a pending increment so the bin read below sees final counts
        if (!ram_pend) begin
          if (accum_q) begin
            avmm_0_rw_read    = 1'b1;
            avmm_0_rw_address = wb_addr_q;
            if (!avmm_0_rw_waitrequest) state_d = WB_RDWAIT;
          end else begin
            state_d = WB_WR;
          end
        end
      end
      WB_RDWAIT: begin
        if (avmm_0_rw_readdatavalid) begin
          wb_cap  = 1'b1;
          state_d = WB_WR;
        end
      end
      WB_WR: begin
        avmm_0_rw_write     = 1'b1;
        avmm_0_rw_address   = wb_addr_q;
        avmm_0_rw_writedata = BUS_W'(sum);
        if (!avmm_0_rw_waitrequest) begin
          wr_acc  = 1'b1;
          b_adv   = 1'b1;
          state_d = (b_q == BIN_MAX) ? DONE : WB_REQ;
        end
      end
      DONE: begin
        done = 1'b1;
        if (!stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Call arguments, sample/bin cursors and the out-of-range counter
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_addr_q <= '0;
      wb_addr_q <= '0;
      n_q       <= '0;
      i_q       <= '0;
      oor_q     <= '0;
      b_q       <= '0;
      accum_q   <= 1'b0;
      wb_mem_q  <= '0;
    end else begin
      if (latch) begin
        rd_addr_q <= src_r;
        wb_addr_q <= hist_r;
        n_q       <= n;
        accum_q   <= accum;
        i_q       <= '0;
        oor_q     <= '0;
        b_q       <= '0;
      end
      if (b_adv) b_q <= b_q + BIN_IDX_W'(1);
      if (smp_done) begin
        i_q       <= i_q + 32'd1;
        rd_addr_q <= rd_addr_q + ADDR_W'(BYTES);
        if (!in_range && (oor_q != '1)) oor_q <= oor_q + 32'd1;
      end
      if (wb_cap) wb_mem_q <= avmm_0_rw_readdata[CNT_W-1:0];
      if (wr_acc) wb_addr_q <= wb_addr_q + ADDR_W'(BYTES);
    end
  end

endmodule

// File: tb/tb_histogram_mm.sv
// tb/tb_histogram_mm.sv - directed self-checking bench for histogram_mm
module tb_histogram_mm;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic        busy;
  logic        done;
  logic        stall;
  logic [63:0] src_r;
  logic [63:0] hist_r;
  logic [31:0] n;
  logic        accum;
  logic [31:0] oor_count;
  logic [63:0] address;
  logic [7:0]  byteenable;
  logic        read;
  logic [63:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;
  logic        write;
  logic [63:0] writedata;

  int checks = 0;
  int errors = 0;

  // Memory: pmem is preloaded by the tests, wmem holds what the DUT wrote
  logic [63:0] pmem [logic [63:0]];
  logic [63:0] wmem [logic [63:0]];

  // Test-owned slave/monitor configuration
  int          mode = 0;
  logic [63:0] win_lo = 64'h0;
  logic [63:0] win_hi = 64'h0;
  logic [63:0] src_lo = 64'h0;
  logic [63:0] src_hi = 64'h0;

  // Monitor-owned counters
  int          pend = 0;
  logic [63:0] pend_data = 64'h0;
  int          wr_total = 0;
  int          rd_total = 0;
  int          src_rd_total = 0;
  int          out_wr_total = 0;
  int          done_hi_total = 0;
  int          rw_both_total = 0;

  histogram_mm #(.CNT_W(4)) dut (
    .clock                  (clock),
    .resetn                 (resetn),
    .start                  (start),
    .busy                   (busy),
    .done                   (done),
    .stall                  (stall),
    .src_r                  (src_r),
    .hist_r                 (hist_r),
    .n                      (n),
    .accum                  (accum),
    .oor_count              (oor_count),
    .avmm_0_rw_address      (address),
    .avmm_0_rw_byteenable   (byteenable),
    .avmm_0_rw_read         (read),
    .avmm_0_rw_readdata     (readdata),
    .avmm_0_rw_readdatavalid(readdatavalid),
    .avmm_0_rw_waitrequest  (waitrequest),
    .avmm_0_rw_write        (write),
    .avmm_0_rw_writedata    (writedata)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] fetch(input logic [63:0] a);
    if (wmem.exists(a)) return wmem[a];
    if (pmem.exists(a)) return pmem[a];
    return 64'h0;
  endfunction

  function automatic logic [63:0] bin_at(input logic [63:0] h, input int b);
    logic [63:0] a;
    a = h + 64'(b * 8);
    if (wmem.exists(a)) return wmem[a];
    return 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  // Avalon slave model and bus monitor; decisions made at negedge take effect at the next posedge
  always @(negedge clock) begin
    if (!resetn) begin
      pend          = 0;
      readdatavalid = 1'b0;
      waitrequest   = 1'b0;
      readdata      = 64'h0;
    end else begin
      readdatavalid = 1'b0;
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          readdatavalid = 1'b1;
          readdata      = pend_data;
        end
      end
      waitrequest = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (read && write) rw_both_total++;
      if (done) done_hi_total++;
      if (read && !waitrequest) begin
        rd_total++;
        if (address >= src_lo && address <= src_hi) src_rd_total++;
        pend_data = fetch(address);
        pend      = (mode == 1) ? int'($urandom_range(1, 8)) : (mode == 2) ? 8 : 1;
      end
      if (write && !waitrequest) begin
        wmem[address] = writedata;
        wr_total++;
        if (address < win_lo || address > win_hi) out_wr_total++;
      end
    end
  end

  task automatic do_call(input logic [63:0] s, input logic [63:0] h, input logic [31:0] nn,
                         input logic ac, input int stall_cyc,
                         output bit timed_out, output bit busy_seen, output int held);
    @(negedge clock);
    win_lo = h;
    win_hi = h + 64'd2047;
    src_lo = s;
    src_hi = s + 64'hFFF;
    src_r  = s;
    hist_r = h;
    n      = nn;
    accum  = ac;
    stall  = (stall_cyc > 0);
    start  = 1'b1;
    @(negedge clock);
    start     = 1'b0;
    busy_seen = busy;
    timed_out = 1'b1;
    for (int k = 0; k < 20000; k++) begin
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clock);
    end
    held = 0;
    if (!timed_out) begin
      for (int k = 0; k < stall_cyc; k++) begin
        if (done) held++;
        @(negedge clock);
      end
      stall = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    start  = 1'b0;
    stall  = 1'b0;
    src_r  = 64'h0;
    hist_r = 64'h0;
    n      = 32'h0;
    accum  = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (read !== 1'b0) begin errors++; $display("FAIL reset_read: got %b want 0", read); end
    checks++; if (write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b want 0", write); end
    checks++; if (address !== 64'h0) begin errors++; $display("FAIL reset_address: got %h want 0", address); end
    checks++; if (writedata !== 64'h0) begin errors++; $display("FAIL reset_writedata: got %h want 0", writedata); end
    checks++; if (oor_count !== 32'h0) begin errors++; $display("FAIL reset_oor: got %0d want 0", oor_count); end
    checks++; if (byteenable !== 8'hFF) begin errors++; $display("FAIL byteenable: got %h want ff", byteenable); end
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic();
    bit to, bs;
    int held, w0, d0, bad;
    logic [63:0] h, ex;
    h = 64'h10000;
    pmem[64'h1000] = 64'hFFFF_0000_0000_0003;
    pmem[64'h1008] = 64'h0000_0000_0000_0003;
    pmem[64'h1010] = 64'h1234_5678_0000_0007;
    pmem[64'h1018] = 64'h0000_0000_0000_00FF;
    for (int b = 0; b < 256; b++) pmem[h + 64'(b * 8)] = 64'hAAAA;
    w0 = wr_total;
    d0 = done_hi_total;
    do_call(64'h1000, h, 32'd4, 1'b0, 0, to, bs, held);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout: done never seen"); end
    checks++; if (bs !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", bs); end
    checks++; if (wr_total - w0 !== 256) begin errors++; $display("FAIL basic_writes: got %0d want 256", wr_total - w0); end
    checks++; if (bin_at(h, 3) !== 64'd2) begin errors++; $display("FAIL basic_bin3: got %h want 2", bin_at(h, 3)); end
    checks++; if (bin_at(h, 7) !== 64'd1) begin errors++; $display("FAIL basic_bin7: got %h want 1", bin_at(h, 7)); end
    checks++; if (bin_at(h, 255) !== 64'd1) begin errors++; $display("FAIL basic_bin255: got %h want 1", bin_at(h, 255)); end
    bad = 0;
    for (int b = 0; b < 256; b++) begin
      ex = (b == 3) ? 64'd2 : (b == 7 || b == 255) ? 64'd1 : 64'd0;
      if (bin_at(h, b) !== ex) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL basic_all_bins: %0d bins wrong, want 0", bad); end
    checks++; if (oor_count !== 32'd0) begin errors++; $display("FAIL basic_oor: got %0d want 0", oor_count); end
    checks++; if (done_hi_total - d0 !== 1) begin errors++; $display("FAIL basic_done_cycles: got %0d want 1", done_hi_total - d0); end
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle: done %b busy %b want 0 0", done, busy); end
  endtask

  task automatic test_accum();
    bit to, bs;
    int held, w0, r0, bad;
    logic [63:0] h, ex;
    h = 64'h20000;
    pmem[64'h2000] = 64'd3;
    pmem[64'h2008] = 64'd5;
    pmem[64'h2010] = 64'd5;
    for (int b = 0; b < 256; b++) pmem[h + 64'(b * 8)] = 64'h1234_0000_0000_0000 | 64'(b % 8);
    pmem[h + 64'd24] = 64'h1234_0000_0000_000A;
    pmem[h + 64'd40] = 64'h0000_0000_0000_000E;
    w0 = wr_total;
    r0 = rd_total;
    do_call(64'h2000, h, 32'd3, 1'b1, 0, to, bs, held);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL accum_timeout: done never seen"); end
    checks++; if (bin_at(h, 3) !== 64'd11) begin errors++; $display("FAIL accum_bin3: got %h want 11", bin_at(h, 3)); end
    checks++; if (bin_at(h, 5) !== 64'd15) begin errors++; $display("FAIL accum_bin5_sat: got %h want 15", bin_at(h, 5)); end
    bad = 0;
    for (int b = 0; b < 256; b++) begin
      ex = (b == 3) ? 64'd11 : (b == 5) ? 64'd15 : 64'(b % 8);
      if (bin_at(h, b) !== ex) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL accum_all_bins: %0d bins wrong, want 0", bad); end
    checks++; if (wr_total - w0 !== 256) begin errors++; $display("FAIL accum_writes: got %0d want 256", wr_total - w0); end
    checks++; if (rd_total - r0 !== 259) begin errors++; $display("FAIL accum_reads: got %0d want 259", rd_total - r0); end
  endtask

  task automatic test_oor();
    bit to, bs;
    int held, w0, o0;
    logic [63:0] h;
    h = 64'h30000;
    pmem[64'h3000] = 64'd256;
    pmem[64'h3008] = 64'd1000;
    pmem[64'h3010] = 64'd5;
    w0 = wr_total;
    o0 = out_wr_total;
    do_call(64'h3000, h, 32'd3, 1'b0, 0, to, bs, held);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL oor_timeout: done never seen"); end
    checks++; if (oor_count !== 32'd2) begin errors++; $display("FAIL oor_count: got %0d want 2", oor_count); end
    checks++; if (bin_at(h, 5) !== 64'd1) begin errors++; $display("FAIL oor_bin5: got %h want 1", bin_at(h, 5)); end
    checks++; if (bin_at(h, 0) !== 64'd0) begin errors++; $display("FAIL oor_bin0: got %h want 0", bin_at(h, 0)); end
    checks++; if (out_wr_total - o0 !== 0) begin errors++; $display("FAIL oor_stray_writes: got %0d want 0", out_wr_total - o0); end
    checks++; if (wr_total - w0 !== 256) begin errors++; $display("FAIL oor_writes: got %0d want 256", wr_total - w0); end
  endtask

  task automatic test_n_zero();
    bit to, bs;
    int held, w0, s0, d0, bad;
    logic [63:0] h;
    h = 64'h40000;
    pmem[64'h4000] = 64'd9;
    w0 = wr_total;
    s0 = src_rd_total;
    d0 = done_hi_total;
    do_call(64'h4000, h, 32'd0, 1'b0, 0, to, bs, held);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL nzero_timeout: done never seen"); end
    checks++; if (wr_total - w0 !== 256) begin errors++; $display("FAIL nzero_writes: got %0d want 256", wr_total - w0); end
    checks++; if (src_rd_total - s0 !== 0) begin errors++; $display("FAIL nzero_src_reads: got %0d want 0", src_rd_total - s0); end
    bad = 0;
    for (int b = 0; b < 256; b++) if (bin_at(h, b) !== 64'd0) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL nzero_bins: %0d bins nonzero, want 0", bad); end
    checks++; if (oor_count !== 32'd0) begin errors++; $display("FAIL nzero_oor_cleared: got %0d want 0", oor_count); end
    checks++; if (done_hi_total - d0 !== 1) begin errors++; $display("FAIL nzero_done_cycles: got %0d want 1", done_hi_total - d0); end
  endtask

  task automatic test_random_stall();
    bit to, bs;
    int held, w0, d0, bad;
    logic [63:0] h, ex;
    h = 64'h50000;
    mode = 1;
    w0 = wr_total;
    d0 = done_hi_total;
    do_call(64'h1000, h, 32'd4, 1'b0, 5, to, bs, held);
    mode = 0;
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL rand_timeout: done never seen"); end
    checks++; if (held !== 5) begin errors++; $display("FAIL rand_done_held: got %0d want 5", held); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rand_done_drop: got %b want 0", done); end
    checks++; if (done_hi_total - d0 !== 6) begin errors++; $display("FAIL rand_done_cycles: got %0d want 6", done_hi_total - d0); end
    checks++; if (wr_total - w0 !== 256) begin errors++; $display("FAIL rand_writes: got %0d want 256", wr_total - w0); end
    bad = 0;
    for (int b = 0; b < 256; b++) begin
      ex = (b == 3) ? 64'd2 : (b == 7 || b == 255) ? 64'd1 : 64'd0;
      if (bin_at(h, b) !== ex) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rand_bins: %0d bins wrong, want 0", bad); end
  endtask

  task automatic test_reset_mid_and_saturate();
    bit to, bs, seen;
    int held, bad;
    logic [63:0] h;
    for (int j = 0; j < 4; j++) pmem[64'h6000 + 64'(j * 8)] = 64'(j + 1);
    mode = 2;
    @(negedge clock);
    src_r  = 64'h6000;
    hist_r = 64'h60000;
    n      = 32'd4;
    accum  = 1'b0;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (read) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL mid_read_seen: no read issued"); end
    @(negedge clock);
    resetn = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    checks++; if (read !== 1'b0 || write !== 1'b0) begin errors++; $display("FAIL mid_reset_bus: read %b write %b want 0 0", read, write); end
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    mode   = 0;
    h = 64'h70000;
    for (int j = 0; j < 20; j++) pmem[64'h7000 + 64'(j * 8)] = 64'd0;
    do_call(64'h7000, h, 32'd20, 1'b0, 0, to, bs, held);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL sat_timeout: done never seen"); end
    checks++; if (bin_at(h, 0) !== 64'd15) begin errors++; $display("FAIL sat_bin0: got %h want 15", bin_at(h, 0)); end
    bad = 0;
    for (int b = 1; b < 256; b++) if (bin_at(h, b) !== 64'd0) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL sat_other_bins: %0d bins wrong, want 0", bad); end
    checks++; if (oor_count !== 32'd0) begin errors++; $display("FAIL sat_oor: got %0d want 0", oor_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_accum();
    test_oor();
    test_n_zero();
    test_random_stall();
    test_reset_mid_and_saturate();
    checks++; if (rw_both_total !== 0) begin errors++; $display("FAIL read_write_overlap: got %0d want 0", rw_both_total); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
